// File: rtl/approx_final_adder_seq_if.sv
// approx_final_adder_seq_if
// Groups the row-pair input handshake and the product output handshake of
// approx_final_adder_seq into one bundle.
//   in_valid / in_ready : row pair offered / accepted
//   row_s, row_c        : sum and carry rows from the compressor tree
//   out_valid/out_ready : product offered / consumed
//   product, cout       : row_s + row_c mod 2^WIDTH, and the overflow bit
// master = upstream producer plus downstream consumer (testbench side),
// slave  = the adder itself.
interface approx_final_adder_seq_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] row_s;
  logic [WIDTH-1:0] row_c;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] product;
  logic             cout;

  modport master (
    output in_valid, row_s, row_c, out_ready,
    input  in_ready, out_valid, product, cout
  );

  modport slave (
    input  in_valid, row_s, row_c, out_ready,
    output in_ready, out_valid, product, cout
  );
endinterface

// File: rtl/approx_final_adder_seq.sv
// approx_final_adder_seq
// Final carry-propagate stage after the approximate 4:2 compressor tree.
// Adds the sum row and the carry row CHUNK bits per cycle so the carry chain
// is only CHUNK bits long. One operation at a time: IDLE accepts a row pair,
// ADD spends exactly NCHUNK cycles on it, HOLD presents the product until the
// consumer takes it.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - approx_final_adder_seq_if.slave (in_valid/in_ready/row_s/row_c,
//          out_valid/out_ready/product/cout)
// Optional macro APPROX_LOA_EN: the lowest LOA_BITS bits are produced by a
// lower-part-OR adder (bitwise OR, carry into the exact part is the AND of the
// top approximated bit pair). Without the macro every chunk is exact and
// LOA_BITS is ignored.
module approx_final_adder_seq #(
  parameter int WIDTH    = 16,
  parameter int CHUNK    = 4,
  parameter int LOA_BITS = 4
) (
  input logic                    clk,
  input logic                    rst,
  approx_final_adder_seq_if.slave bus
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADD  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  // Reject parameter sets the chunked datapath cannot represent.
  if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_width
    $error("approx_final_adder_seq: WIDTH must be a positive multiple of CHUNK");
  end

`ifdef APPROX_LOA_EN
  if (LOA_BITS < 0 || LOA_BITS >= WIDTH || (LOA_BITS % CHUNK) != 0) begin : g_bad_loa
    $error("approx_final_adder_seq: LOA_BITS must be a multiple of CHUNK in [0, WIDTH)");
  end
`endif

  logic [1:0]       state;
  logic [IDX_W-1:0] idx;
  logic             carry;
  logic [WIDTH-1:0] row_s_r;
  logic [WIDTH-1:0] row_c_r;
  logic [WIDTH-1:0] product_r;
  logic             cout_r;

  logic [CHUNK-1:0] chunk_s;
  logic [CHUNK-1:0] chunk_c;
  logic [CHUNK:0]   exact_sum;
  logic [CHUNK-1:0] chunk_sum;
  logic             chunk_carry;

  // Operand slice for the chunk currently being added.
  assign chunk_s   = row_s_r[idx*CHUNK +: CHUNK];
  assign chunk_c   = row_c_r[idx*CHUNK +: CHUNK];
  assign exact_sum = {1'b0, chunk_s} + {1'b0, chunk_c} + {{CHUNK{1'b0}}, carry};

`ifdef APPROX_LOA_EN
  if (LOA_BITS > 0) begin : g_loa
    localparam int LOA_CHUNKS = LOA_BITS / CHUNK;

    // Lower chunks OR the rows; the last approximated chunk hands the AND of
    // its top bit pair to the first exact chunk as the carry.
    always_comb begin
      chunk_sum   = exact_sum[CHUNK-1:0];
      chunk_carry = exact_sum[CHUNK];
      if (idx < IDX_W'(LOA_CHUNKS)) begin
        chunk_sum   = chunk_s | chunk_c;
        chunk_carry = (idx == IDX_W'(LOA_CHUNKS - 1)) ?
                      (row_s_r[LOA_BITS-1] & row_c_r[LOA_BITS-1]) : 1'b0;
      end
    end
  end else begin : g_exact
    assign chunk_sum   = exact_sum[CHUNK-1:0];
    assign chunk_carry = exact_sum[CHUNK];
  end
`else
  assign chunk_sum   = exact_sum[CHUNK-1:0];
  assign chunk_carry = exact_sum[CHUNK];
`endif

  // Control and datapath registers. Reset aborts any operation in flight, so
  // a result interrupted in ADD or HOLD is never presented.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      idx       <= '0;
      carry     <= 1'b0;
      row_s_r   <= '0;
      row_c_r   <= '0;
      product_r <= '0;
      cout_r    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            row_s_r <= bus.row_s;
            row_c_r <= bus.row_c;
            idx     <= '0;
            carry   <= 1'b0;
            state   <= ST_ADD;
          end
        end
        ST_ADD: begin
          product_r[idx*CHUNK +: CHUNK] <= chunk_sum;
          carry                         <= chunk_carry;
          if (idx == LAST_IDX) begin
            cout_r <= chunk_carry;
            state  <= ST_HOLD;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        ST_HOLD: begin
          if (bus.out_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // in_ready is forced low while reset is asserted, even in IDLE.
  assign bus.in_ready  = (state == ST_IDLE) && !rst;
  assign bus.out_valid = (state == ST_HOLD);
  assign bus.product   = product_r;
  assign bus.cout      = cout_r;

endmodule

// File: tb/tb_approx_final_adder_seq.sv
// tb_approx_final_adder_seq
// Scoreboard bench for approx_final_adder_seq (WIDTH=16, CHUNK=4, LOA_BITS=4).
// Stimulus pushes hand-computed results into a queue when a row pair is
// accepted; a monitor thread pops and compares whenever a product is taken.
// Vectors that differ with APPROX_LOA_EN carry both expected values.
module tb_approx_final_adder_seq;

  localparam int WIDTH  = 16;
  localparam int NCHUNK = 4;

  typedef struct packed {
    logic [WIDTH-1:0] p;
    logic             c;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   accept_cyc = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  // Free-running edge counter used to measure accept-to-valid latency.
  always @(posedge clk) cyc <= cyc + 1;

  approx_final_adder_seq_if #(.WIDTH(WIDTH)) bus ();

  approx_final_adder_seq #(
    .WIDTH(WIDTH),
    .CHUNK(4),
    .LOA_BITS(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Offers one row pair, waits (bounded) for acceptance, then scrambles the
  // rows so the DUT must have captured them.
  task automatic applyStimulus(input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] c,
                               input logic [WIDTH-1:0] ep, input logic ec, input bit push);
    int n;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.row_s    = s;
    bus.row_c    = c;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      total++;
      bad++;
      $display("[TB] FAIL accept_timeout: in_ready got 0 expected 1");
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    accept_cyc = cyc;
    if (push) sb.push_back('{p: ep, c: ec});
    bus.in_valid = 1'b0;
    bus.row_s    = WIDTH'($urandom);
    bus.row_c    = WIDTH'($urandom);
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while ((sb.size() != 0 || bus.out_valid) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0 || bus.out_valid) begin
      total++;
      bad++;
      $display("[TB] FAIL drain_timeout: pending got %0d expected 0", sb.size());
    end
  endtask

  initial begin
    int n;
    int seen;

    // Monitor: compares each product the consumer takes against the queue.
    fork
      begin
        logic prev_valid;
        exp_t e;
        prev_valid = 1'b0;
        forever begin
          @(negedge clk);
          if (bus.out_valid && !prev_valid)
            checkOutput("latency", cyc - accept_cyc + 1, NCHUNK + 1);
          if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
              total++;
              bad++;
              $display("[TB] FAIL unexpected_output: product 0x%0h with empty scoreboard", bus.product);
            end else begin
              e = sb.pop_front();
              checkOutput("product", bus.product, e.p);
              checkOutput("cout", bus.cout, e.c);
            end
          end
          prev_valid = bus.out_valid;
        end
      end
    join_none

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.row_s     = '0;
    bus.row_c     = '0;
    bus.out_ready = 1'b1;

    // Power-on reset.
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst_out_valid", bus.out_valid, 0);
    checkOutput("rst_product", bus.product, 0);
    checkOutput("rst_cout", bus.cout, 0);
    checkOutput("rst_in_ready", bus.in_ready, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_in_ready", bus.in_ready, 1);

    // Carry ripples across chunk boundaries 1 and 2.
    applyStimulus(16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b1);
    waitDrain();

    // Reset mid-run clears the held product; two cycles of rst.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst_out_valid", bus.out_valid, 0);
    checkOutput("midrst_product", bus.product, 0);
    checkOutput("midrst_cout", bus.cout, 0);
    checkOutput("midrst_in_ready", bus.in_ready, 0);
    @(negedge clk);
    checkOutput("midrst_in_ready2", bus.in_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midrst_release_in_ready", bus.in_ready, 1);

    // Overflow, then an ordinary add, issued back to back.
    applyStimulus(16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1);
    applyStimulus(16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b1);
    waitDrain();

    // Backpressure: product held, new rows refused while in HOLD.
    bus.out_ready = 1'b0;
    applyStimulus(16'hAAAA, 16'h1111, 16'hBBBB, 1'b0, 1'b1);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("bp_out_valid", bus.out_valid, 1);
    bus.in_valid = 1'b1;
    bus.row_s    = 16'h0F0F;
    bus.row_c    = 16'h0101;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("bp_in_ready", bus.in_ready, 0);
      checkOutput("bp_hold_valid", bus.out_valid, 1);
      checkOutput("bp_product", bus.product, 16'hBBBB);
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    applyStimulus(16'h0F0F, 16'h0101, 16'h1010, 1'b0, 1'b1);
    waitDrain();

    // Reset pulsed in the second ADD cycle: no result may appear.
    applyStimulus(16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    checkOutput("abort_no_valid", seen, 0);
    applyStimulus(16'h0003, 16'h0004, 16'h0007, 1'b0, 1'b1);
    waitDrain();

    // Lower-part vectors: exact results unless APPROX_LOA_EN is defined.
`ifdef APPROX_LOA_EN
    applyStimulus(16'h000F, 16'h0001, 16'h000F, 1'b0, 1'b1);
    applyStimulus(16'h0008, 16'h0008, 16'h0018, 1'b0, 1'b1);
`else
    applyStimulus(16'h000F, 16'h0001, 16'h0010, 1'b0, 1'b1);
    applyStimulus(16'h0008, 16'h0008, 16'h0010, 1'b0, 1'b1);
`endif
    applyStimulus(16'h0100, 16'h0200, 16'h0300, 1'b0, 1'b1);
    waitDrain();

    checkOutput("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
